// File: rtl/kmap_pkg.sv
// Shared types and sizing for the K-map response checker.
// The top module takes N_IN as a parameter; N_IN_DEF/TBL_W here are the defaults.
package kmap_pkg;
  localparam int N_IN_DEF = 4;
  localparam int TBL_W    = 2**N_IN_DEF;
  localparam int IDX_W    = N_IN_DEF;
  localparam int TMR_W    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Reload value for the settle timer: a window of n cycles counts n-1 down to 0.
  function automatic logic [TMR_W-1:0] settle_reload(input int n);
    return TMR_W'(n - 1);
  endfunction
endpackage

// File: rtl/kmap_settle_timer.sv
// Settle-window down-counter: load arms it, expire_o pulses on the last
// cycle of the window while en_i is high.
module kmap_settle_timer
  import kmap_pkg::*;
#(
  parameter int SETTLE_CYC = 2  // 1..255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Reload on load, otherwise count down while enabled and not yet at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = settle_reload(SETTLE_CYC);
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = en_i && !load_i && (cnt_q == '0);
endmodule

// File: rtl/kmap_response_checker.sv
// Exhaustive truth-table sweeper: walks vec_out over every input vector,
// waits SETTLE_CYC cycles, samples f_in, and compares against a latched mask.
// Optional first-mismatch capture is built when KMAP_FIRST_ERR_LOG_EN is defined.
module kmap_response_checker
  import kmap_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int SETTLE_CYC = 2   // 1..255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        err_cnt,
  output logic                 first_err_vld,
  output logic [N_IN-1:0]      first_err_idx
);
  localparam int TW = 2**N_IN;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [TW-1:0]   exp_q, exp_d;
  logic [TW-1:0]   table_q, table_d;
  logic [N_IN:0]   err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            tmr_load, tmr_expire;
  logic            start_ok, last_idx, mism, do_sample;

  kmap_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tmr_load),
    .en_i     (state_q == SETTLE),
    .expire_o (tmr_expire)
  );

  assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_idx  = &idx_q;
  assign mism      = (f_in != exp_q[idx_q]);
  assign do_sample = (state_q == SAMPLE);

  // Sweep FSM and result accumulation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    exp_d    = exp_q;
    table_d  = table_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          exp_d    = expected;
          table_d  = '0;
          err_d    = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          idx_d    = '0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_expire) state_d = SAMPLE;
      end
      SAMPLE: begin
        table_d[idx_q] = f_in;
        if (mism) err_d = err_q + 1'b1;
        if (last_idx) begin
          // A start arriving here is ignored: the state is not IDLE/DONE yet.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == '0);
          state_d = DONE;
        end else begin
          idx_d    = idx_q + 1'b1;
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // vec_out always tracks the current index; it rests at all-ones in DONE.
  assign vec_out   = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign table_out = table_q;
  assign err_cnt   = err_q;

`ifdef KMAP_FIRST_ERR_LOG_EN
  logic            fev_q;
  logic [N_IN-1:0] fei_q;

  // Capture the index of the first mismatch of a sweep; cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fev_q <= 1'b0;
      fei_q <= '0;
    end else if (start_ok) begin
      fev_q <= 1'b0;
      fei_q <= '0;
    end else if (do_sample && mism && !fev_q) begin
      fev_q <= 1'b1;
      fei_q <= idx_q;
    end
  end

  assign first_err_vld = fev_q;
  assign first_err_idx = fei_q;
`else
  logic unused_fe;
  assign unused_fe     = do_sample;
  assign first_err_vld = 1'b0;
  assign first_err_idx = '0;
`endif
endmodule
